// File: rtl/decoder_nto2n_reg.sv
// decoder_nto2n_reg: registered N-to-2^N one-hot/one-cold decoder with valid/ready accept and hold.
// Optional walking-one self-test scan is built only when DECODER_SCAN_EN is defined.
module decoder_nto2n_reg #(
    parameter int SEL_W      = 3,
    parameter int SCAN_DIV   = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    scan_start,
    output logic [(1<<SEL_W)-1:0]   y,
    output logic                    y_valid,
    output logic                    scan_busy,
    output logic                    scan_done
);
    localparam int OUT_W = 1 << SEL_W;
    localparam logic [OUT_W-1:0] INACT = ACTIVE_LOW ? '1 : '0;

    typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

    state_t state_q, state_d;
    logic [OUT_W-1:0] y_q, y_d;

    function automatic logic [OUT_W-1:0] act(input logic [SEL_W-1:0] idx);
        return INACT ^ (OUT_W'(1) << idx);
    endfunction

`ifdef DECODER_SCAN_EN
    logic [SEL_W-1:0] step_q, step_d;
    logic [7:0]       div_q, div_d;
    logic             done_q, done_d;
    logic             scan_last;

    assign scan_last = div_q == 8'(SCAN_DIV - 1);
    assign in_ready  = en & (state_q != SCAN) & ~scan_start;
    assign scan_busy = state_q == SCAN;
    assign scan_done = done_q;

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        step_d  = step_q;
        div_d   = div_q;
        done_d  = 1'b0;
        if (!en) begin
            state_d = IDLE;
            y_d     = INACT;
            step_d  = '0;
            div_d   = '0;
        end else if (scan_start && state_q != SCAN) begin
            state_d = SCAN;
            y_d     = act('0);
            step_d  = '0;
            div_d   = '0;
        end else if (state_q == SCAN) begin
            div_d = scan_last ? 8'd0 : div_q + 8'd1;
            // the last step ends the scan instead of wrapping back to output 0
            if (scan_last && step_q == SEL_W'(OUT_W - 1)) begin
                state_d = IDLE;
                y_d     = INACT;
                step_d  = '0;
                done_d  = 1'b1;
            end else if (scan_last) begin
                step_d = step_q + 1'b1;
                y_d    = act(step_q + 1'b1);
            end
        end else if (in_valid) begin
            state_d = HOLD;
            y_d     = act(sel);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= '0;
            div_q  <= '0;
            done_q <= 1'b0;
        end else begin
            step_q <= step_d;
            div_q  <= div_d;
            done_q <= done_d;
        end
    end
`else
    logic unused_scan_start;

    assign unused_scan_start = scan_start;
    assign in_ready  = en;
    assign scan_busy = 1'b0;
    assign scan_done = 1'b0;

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        if (!en) begin
            state_d = IDLE;
            y_d     = INACT;
        end else if (in_valid) begin
            state_d = HOLD;
            y_d     = act(sel);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= INACT;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
        end
    end

    assign y       = y_q;
    assign y_valid = state_q != IDLE;
endmodule

// File: tb/tb_decoder_nto2n_reg.sv
// tb_decoder_nto2n_reg: table-driven check of accept/hold/enable behaviour, both polarities.
// Scan sequences are exercised when DECODER_SCAN_EN is defined; otherwise scan_start is shown to be ignored.
module tb_decoder_nto2n_reg;
    logic       clk = 1'b0;
    logic       rst_n, en, in_valid, scan_start;
    logic [2:0] sel;
    logic       in_ready, y_valid, scan_busy, scan_done;
    logic [7:0] y;
    logic       in_ready_al, y_valid_al, scan_busy_al, scan_done_al;
    logic [7:0] y_al;
    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic       en;
        logic       iv;
        logic [2:0] sel;
        logic [7:0] ey;
        logic       ev;
    } vec_t;

    vec_t tv [13];

    always #5 clk = ~clk;

    decoder_nto2n_reg #(.SEL_W(3), .SCAN_DIV(2), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .scan_start(scan_start), .y(y), .y_valid(y_valid),
        .scan_busy(scan_busy), .scan_done(scan_done)
    );

    decoder_nto2n_reg #(.SEL_W(3), .SCAN_DIV(2), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready_al),
        .sel(sel), .scan_start(scan_start), .y(y_al), .y_valid(y_valid_al),
        .scan_busy(scan_busy_al), .scan_done(scan_done_al)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [7:0] e;
        logic       saw_done;
        tv[0]  = '{1'b1, 1'b1, 3'd0, 8'h01, 1'b1};
        tv[1]  = '{1'b1, 1'b1, 3'd2, 8'h04, 1'b1};
        tv[2]  = '{1'b1, 1'b1, 3'd4, 8'h10, 1'b1};
        tv[3]  = '{1'b1, 1'b1, 3'd6, 8'h40, 1'b1};
        tv[4]  = '{1'b1, 1'b0, 3'd1, 8'h40, 1'b1};
        tv[5]  = '{1'b1, 1'b0, 3'd3, 8'h40, 1'b1};
        tv[6]  = '{1'b1, 1'b1, 3'd3, 8'h08, 1'b1};
        tv[7]  = '{1'b0, 1'b1, 3'd5, 8'h00, 1'b0};
        tv[8]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
        tv[9]  = '{1'b1, 1'b0, 3'd7, 8'h00, 1'b0};
        tv[10] = '{1'b1, 1'b1, 3'd7, 8'h80, 1'b1};
        tv[11] = '{1'b1, 1'b1, 3'd7, 8'h80, 1'b1};
        tv[12] = '{1'b1, 1'b0, 3'd0, 8'h80, 1'b1};

        rst_n = 1'b0; en = 1'b1; in_valid = 1'b1; sel = 3'd5; scan_start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_y", y, 8'h00);
        chk("rst_valid", {7'd0, y_valid}, 8'd0);
        chk("rst_busy", {7'd0, scan_busy}, 8'd0);
        chk("rst_done", {7'd0, scan_done}, 8'd0);
        chk("rst_y_al", y_al, 8'hFF);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_y", y, 8'h20);
        chk("rel_valid", {7'd0, y_valid}, 8'd1);

        for (int i = 0; i < 13; i++) begin
            en = tv[i].en; in_valid = tv[i].iv; sel = tv[i].sel;
            @(negedge clk);
            chk($sformatf("v%0d_y", i), y, tv[i].ey);
            chk($sformatf("v%0d_valid", i), {7'd0, y_valid}, {7'd0, tv[i].ev});
            chk($sformatf("v%0d_ready", i), {7'd0, in_ready}, {7'd0, tv[i].en});
            chk($sformatf("v%0d_y_al", i), y_al, tv[i].ey ^ 8'hFF);
        end

`ifdef DECODER_SCAN_EN
        en = 1'b1; in_valid = 1'b1; sel = 3'd1; scan_start = 1'b1;
        #1 chk("scan_entry_ready", {7'd0, in_ready}, 8'd0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            e = 8'h01 << (k / 2);
            chk($sformatf("scan%0d_y", k), y, e);
            chk($sformatf("scan%0d_y_al", k), y_al, e ^ 8'hFF);
            chk($sformatf("scan%0d_busy", k), {7'd0, scan_busy}, 8'd1);
            chk($sformatf("scan%0d_done", k), {7'd0, scan_done}, 8'd0);
            chk($sformatf("scan%0d_ready", k), {7'd0, in_ready}, 8'd0);
            scan_start = (k == 4);
        end
        @(negedge clk);
        chk("scan_end_y", y, 8'h00);
        chk("scan_end_valid", {7'd0, y_valid}, 8'd0);
        chk("scan_end_busy", {7'd0, scan_busy}, 8'd0);
        chk("scan_end_done", {7'd0, scan_done}, 8'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("scan_done_pulse", {7'd0, scan_done}, 8'd0);
        chk("scan_idle_y", y, 8'h00);

        scan_start = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            scan_start = 1'b0;
        end
        chk("abort_pre_y", y, 8'h08);
        en = 1'b0;
        @(negedge clk);
        chk("abort_y", y, 8'h00);
        chk("abort_busy", {7'd0, scan_busy}, 8'd0);
        chk("abort_valid", {7'd0, y_valid}, 8'd0);
        en = 1'b1;
        saw_done = scan_done;
        repeat (20) begin
            @(negedge clk);
            saw_done |= scan_done;
        end
        chk("abort_no_done", {7'd0, saw_done}, 8'd0);

        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstscan_pre_busy", {7'd0, scan_busy}, 8'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstscan_y", y, 8'h00);
        chk("rstscan_busy", {7'd0, scan_busy}, 8'd0);
        chk("rstscan_valid", {7'd0, y_valid}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`else
        en = 1'b1; in_valid = 1'b1; sel = 3'd1; scan_start = 1'b1;
        #1 chk("noscan_ready", {7'd0, in_ready}, 8'd1);
        @(negedge clk);
        chk("noscan_y", y, 8'h02);
        chk("noscan_busy", {7'd0, scan_busy}, 8'd0);
        chk("noscan_done", {7'd0, scan_done}, 8'd0);
        in_valid = 1'b0; scan_start = 1'b0;
        @(negedge clk);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
